// File: rtl/cpu_run_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// cpu_run_ctrl_pkg
// Shared definitions for the CPU run controller slice.
//   mode_t  : run-mode encodings presented on the mode input
//   state_t : controller state enumeration
//   HOLD_W  : width of the core reset hold counter (covers 1..255 cycles)
// ---------------------------------------------------------------------------
package cpu_run_ctrl_pkg;

    typedef enum logic [1:0] {
        MODE_STOP  = 2'b00,
        MODE_RUN   = 2'b01,
        MODE_STEP  = 2'b10,
        MODE_BURST = 2'b11
    } mode_t;

    typedef enum logic [2:0] {
        RST_HOLD,
        IDLE,
        RUN,
        STEP,
        BURST,
        HALTED
    } state_t;

    localparam int HOLD_W = 8;

endpackage

// File: rtl/cpu_run_ctrl_if.sv
// ---------------------------------------------------------------------------
// cpu_run_ctrl_if
// Control/status bundle between a host (master) and the run controller
// (slave).
//   Host -> controller : mode, go, burst_len, halt_req, soft_rst
//   Controller -> host : core_rst, core_en, busy, done, halted, cycle_cnt
// ---------------------------------------------------------------------------
interface cpu_run_ctrl_if
    import cpu_run_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) ();

    mode_t              mode;
    logic               go;
    logic [CNT_W-1:0]   burst_len;
    logic               halt_req;
    logic               soft_rst;

    logic               core_rst;
    logic               core_en;
    logic               busy;
    logic               done;
    logic               halted;
    logic [CNT_W-1:0]   cycle_cnt;

    modport master (
        output mode, go, burst_len, halt_req, soft_rst,
        input  core_rst, core_en, busy, done, halted, cycle_cnt
    );

    modport slave (
        input  mode, go, burst_len, halt_req, soft_rst,
        output core_rst, core_en, busy, done, halted, cycle_cnt
    );

endinterface

// File: rtl/cpu_run_ctrl_en_prescaler.sv
// ---------------------------------------------------------------------------
// en_prescaler
// Free-running divider that raises tick for one clk cycle out of every DIV.
// With DIV=1 tick is permanently high.
//   clk  : system clock
//   rst  : asynchronous active-high reset, clears the divider phase
//   tick : enable strobe, high when the divider reaches its last count
// ---------------------------------------------------------------------------
module en_prescaler #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt;

    // The divider counts 0..DIV-1 and wraps; it never stops, so the phase of
    // tick depends only on the time elapsed since the last hard reset and not
    // on what the controller is doing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (cnt == CW'(DIV - 1)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = (cnt == CW'(DIV - 1));

endmodule

// File: rtl/cpu_run_ctrl.sv
// ---------------------------------------------------------------------------
// cpu_run_ctrl
// Run controller for a small CPU core: sequences the core reset, and gates a
// prescaled clock enable according to the requested run mode (free run,
// single step, fixed-length burst), with halt and soft-restart handling.
//   clk            : system clock, all state on rising edge
//   rst            : asynchronous active-high reset
//   bus (slave)    : mode/go/burst_len/halt_req/soft_rst in,
//                    core_rst/core_en/busy/done/halted/cycle_cnt out
// Parameters:
//   CNT_W      : width of burst length and cycle counter
//   RST_CYCLES : clk cycles core_rst stays high after any reset (1..255)
//   DIV        : core_en prescale ratio (1..65535)
// ---------------------------------------------------------------------------
module cpu_run_ctrl
    import cpu_run_ctrl_pkg::*;
#(
    parameter int CNT_W      = 32,
    parameter int RST_CYCLES = 4,
    parameter int DIV        = 1
) (
    input  logic          clk,
    input  logic          rst,
    cpu_run_ctrl_if.slave bus
);

    state_t             state;
    logic [HOLD_W-1:0]  hold_cnt;
    logic               go_q;
    logic               go_edge;
    logic               tick;
    logic [CNT_W-1:0]   burst_rem;
    logic [CNT_W-1:0]   cycle_cnt;
    logic               cnt_full;

    logic               core_rst_q;
    logic               core_en_q;
    logic               busy_q;
    logic               done_q;
    logic               halted_q;

    en_prescaler #(
        .DIV (DIV)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    // go is a level from the host; one register stage gives the previous
    // sample so that only a 0->1 transition launches a STEP or BURST. The
    // sample is kept up to date in every state, so an edge that happens while
    // busy is simply lost rather than remembered for later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            go_q <= 1'b0;
        end else begin
            go_q <= bus.go;
        end
    end

    assign go_edge  = bus.go & ~go_q;
    assign cnt_full = &cycle_cnt;

    // Main controller. Priority is soft restart, then halt, then the normal
    // state behaviour. core_en and done default low each cycle so they are
    // single-cycle strobes. Whenever core_en is raised the cycle counter is
    // bumped on the same edge, so the two outputs always agree. The hold
    // counter counts edges spent in RST_HOLD: a hard reset leaves it at 0 and
    // the first edge afterwards makes it 1, while a soft restart already
    // counts its own edge and loads 1 directly; either way core_rst stays
    // high for RST_CYCLES full cycles. A STEP finishes on the edge after its
    // single pulse, which is recognised by core_en still being high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= RST_HOLD;
            hold_cnt   <= '0;
            burst_rem  <= '0;
            cycle_cnt  <= '0;
            core_rst_q <= 1'b1;
            core_en_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            halted_q   <= 1'b0;
        end else if (bus.soft_rst) begin
            state      <= RST_HOLD;
            hold_cnt   <= HOLD_W'(1);
            burst_rem  <= '0;
            cycle_cnt  <= '0;
            core_rst_q <= 1'b1;
            core_en_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            halted_q   <= 1'b0;
        end else if (bus.halt_req && (state != RST_HOLD)) begin
            state     <= HALTED;
            core_en_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            halted_q  <= 1'b1;
        end else begin
            core_en_q <= 1'b0;
            done_q    <= 1'b0;
            case (state)
                RST_HOLD: begin
                    if (hold_cnt == HOLD_W'(RST_CYCLES)) begin
                        state      <= IDLE;
                        core_rst_q <= 1'b0;
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end

                IDLE: begin
                    if (bus.mode == MODE_RUN) begin
                        state  <= RUN;
                        busy_q <= 1'b1;
                    end else if ((bus.mode == MODE_STEP) && go_edge) begin
                        state  <= STEP;
                        busy_q <= 1'b1;
                    end else if ((bus.mode == MODE_BURST) && go_edge) begin
                        state     <= BURST;
                        burst_rem <= bus.burst_len;
                        busy_q    <= 1'b1;
                    end
                end

                RUN: begin
                    if (bus.mode != MODE_RUN) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end else if (tick) begin
                        core_en_q <= 1'b1;
                        if (!cnt_full) begin
                            cycle_cnt <= cycle_cnt + CNT_W'(1);
                        end
                    end
                end

                STEP: begin
                    if (bus.mode == MODE_STOP) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end else if (core_en_q) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end else if (tick) begin
                        core_en_q <= 1'b1;
                        if (!cnt_full) begin
                            cycle_cnt <= cycle_cnt + CNT_W'(1);
                        end
                    end
                end

                BURST: begin
                    if (bus.mode == MODE_STOP) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end else if (burst_rem == '0) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end else if (tick) begin
                        core_en_q <= 1'b1;
                        burst_rem <= burst_rem - CNT_W'(1);
                        if (!cnt_full) begin
                            cycle_cnt <= cycle_cnt + CNT_W'(1);
                        end
                    end
                end

                HALTED: begin
                    halted_q <= 1'b1;
                end

                default: begin
                    state      <= RST_HOLD;
                    hold_cnt   <= HOLD_W'(1);
                    core_rst_q <= 1'b1;
                    busy_q     <= 1'b0;
                    halted_q   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.core_rst  = core_rst_q;
    assign bus.core_en   = core_en_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.halted    = halted_q;
    assign bus.cycle_cnt = cycle_cnt;

endmodule

// File: doc/cpu_run_ctrl.md
CPU_RUN_CTRL -- requirements
Module: cpu_run_ctrl

Interface
REQ-001 Parameter CNT_W, default 32: width of burst length and cycle counter.
REQ-002 Parameter RST_CYCLES, default 4: number of clk cycles core_rst is held high after any reset (range 1..255).
REQ-003 Parameter DIV, default 1: core_en prescale ratio, with one tick every DIV clk cycles (range 1..65535).
REQ-004 clk  in  1  single system clock; all state is updated on the rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 mode  in  2  run mode: 00 STOP, 01 RUN, 10 STEP, 11 BURST.
REQ-007 go  in  1  level input; its rising edge launches STEP or BURST.
REQ-008 burst_len  in  CNT_W  number of core_en pulses per burst.
REQ-009 halt_req  in  1  level input from core: halt instruction reached.
REQ-010 soft_rst  in  1  synchronous single-cycle request to restart the core.
REQ-011 core_rst  out  1  reset to the core, active-high.
REQ-012 core_en  out  1  single-cycle clock enable to the core.
REQ-013 busy  out  1  high in RUN, STEP and BURST states.
REQ-014 done  out  1  one-cycle pulse when a STEP or BURST completes normally.
REQ-015 halted  out  1  high while in HALTED state.
REQ-016 cycle_cnt  out  CNT_W  number of core_en pulses issued since last reset; saturating.

Function
REQ-017 States SHALL be RST_HOLD, IDLE, RUN, STEP, BURST and HALTED.
REQ-018 RST_HOLD SHALL hold core_rst=1 for exactly RST_CYCLES clk cycles, then go to IDLE with core_rst=0.
REQ-019 go SHALL be registered once; a rising edge is go=1 while the previous sample was 0, and the edge SHALL act one cycle after go rises.
REQ-020 In IDLE, the target state SHALL be:
- RUN when mode=01 (level, no edge needed);
- STEP when mode=10 and a go edge occurs;
- BURST when mode=11 and a go edge occurs.
REQ-021 The prescaler SHALL free-run from reset and assert a tick every DIV clk cycles; core_en SHALL be 1 only on a tick while in RUN, STEP or BURST.
- With DIV=1, every cycle is a tick.
REQ-022 RUN SHALL return to IDLE the cycle after mode leaves 01; no partial pulses.
REQ-023 STEP SHALL issue exactly one core_en, then pulse done and return to IDLE.
REQ-024 BURST SHALL load burst_len at entry and issue exactly that many core_en pulses, then pulse done and return to IDLE.
- burst_len=0 SHALL issue no pulse and pulse done the cycle after entry.
REQ-025 mode=00 during BURST or STEP SHALL abort to IDLE without pulsing done.
REQ-026 halt_req=1 in any state other than RST_HOLD SHALL move to HALTED on the next edge.
- core_en SHALL be 0 in that cycle and onward.
- halt_req SHALL win over go, mode and a pending done.
REQ-027 HALTED SHALL be left only via soft_rst or rst.
REQ-028 soft_rst=1 in any state SHALL enter RST_HOLD on the next edge and clear cycle_cnt.
- soft_rst SHALL win over halt_req.
REQ-029 cycle_cnt SHALL increment on every core_en and hold at 2^CNT_W-1.
REQ-030 go edges SHALL be ignored outside IDLE; they are not queued.

Reset
REQ-031 rst SHALL force state RST_HOLD, core_rst=1, core_en=0, busy=0, done=0, halted=0, cycle_cnt=0 and prescaler=0, independent of clk.
REQ-032 The RST_HOLD count SHALL start on the first clk edge after rst deasserts.

Structure
REQ-033 The shared package SHALL hold the mode encodings (MODE_STOP, MODE_RUN, MODE_STEP, MODE_BURST) and the state enumeration.
REQ-034 The prescaler SHALL be a sub-module, en_prescaler, with parameter DIV and ports clk, rst, tick.

Verification
REQ-035 The bench SHALL cover these directed scenarios:
- DIV=1, RST_CYCLES=4, release rst -> core_rst high for exactly 4 cycles, then IDLE.
- mode=01 for 10 cycles with DIV=3, then mode=00 -> 3 or 4 core_en pulses, cycle_cnt matches, no pulse after return to IDLE.
- mode=11, burst_len=5, go edge -> exactly 5 core_en, done pulse once, cycle_cnt=5; burst_len=0 -> 0 pulses and done.
- halt_req asserted during a burst of 100 on the same cycle as a go edge -> halted=1, no further core_en, no done; soft_rst -> RST_HOLD, cycle_cnt=0.
- CNT_W=4 with mode=01 for 20 ticks -> cycle_cnt saturates at 15.
- rst asserted mid-BURST between clk edges -> outputs take reset values immediately.
